// File: rtl/freq_gate_counter.sv
`default_nettype none
// ============================================================================
// freq_gate_counter : Avalon-MM gate generator and rising-edge counter for the
// frequency meter. Optional macro FREQ_GATE_IRQ_EN adds irq = DONE & IE.
// Revision: 1.0
// ============================================================================
module freq_gate_counter #(
  parameter int CNT_W  = 32,
  parameter int GATE_W = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        sig_in,
  output logic        gate_out
`ifdef FREQ_GATE_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam logic [1:0]       c_ADDR_CTRL     = 2'd0;
  localparam logic [1:0]       c_ADDR_GATE_LEN = 2'd1;
  localparam logic [1:0]       c_ADDR_COUNT    = 2'd2;
  localparam logic [1:0]       c_ADDR_STATUS   = 2'd3;
  localparam logic [CNT_W-1:0] c_CNT_MAX       = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GATE = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t              r_state, w_state_nxt;
  logic                r_gate, w_gate_nxt;
  logic [GATE_W-1:0]   r_timer, w_timer_nxt;
  logic [GATE_W-1:0]   r_shadow, w_shadow_nxt;
  logic [GATE_W-1:0]   r_gate_len;
  logic [CNT_W-1:0]    r_edge_cnt, w_edge_cnt_nxt;
  logic [CNT_W-1:0]    r_count, w_count_nxt;
  logic                r_done, r_ovf, r_cont;
  logic                w_done_set, w_ovf_set, w_ovf_clr;
  logic                r_s1, r_s2, r_s3;
  logic [31:0]         r_rdata, w_rdata;
  logic                w_ie;

  logic w_wr, w_wr_ctrl, w_wr_gate_len, w_wr_status;
  logic w_start, w_cont_nxt, w_edge, w_busy;
  logic w_unused;

  assign w_wr          = chipselect & ~write_n;
  assign w_wr_ctrl     = w_wr && (address == c_ADDR_CTRL);
  assign w_wr_gate_len = w_wr && (address == c_ADDR_GATE_LEN);
  assign w_wr_status   = w_wr && (address == c_ADDR_STATUS);

  // CONT as it will be after this cycle, so a write landing in GAP takes effect at once
  assign w_cont_nxt = w_wr_ctrl ? writedata[1] : r_cont;
  assign w_start    = w_wr_ctrl & writedata[0] & (r_gate_len != '0);
  assign w_edge     = r_s2 & ~r_s3;
  assign w_busy     = (r_state != S_IDLE);
  assign w_unused   = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= sig_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_gate_nxt     = r_gate;
    w_timer_nxt    = r_timer;
    w_shadow_nxt   = r_shadow;
    w_edge_cnt_nxt = r_edge_cnt;
    w_count_nxt    = r_count;
    w_done_set     = 1'b0;
    w_ovf_set      = 1'b0;
    w_ovf_clr      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_nxt    = S_GATE;
          w_gate_nxt     = 1'b1;
          w_timer_nxt    = r_gate_len - GATE_W'(1);
          w_shadow_nxt   = r_gate_len;
          w_edge_cnt_nxt = '0;
          w_ovf_clr      = 1'b1;
        end
      end
      S_GATE: begin
        if (w_edge) begin
          if (r_edge_cnt == c_CNT_MAX) begin
            w_ovf_set = 1'b1;
          end else begin
            w_edge_cnt_nxt = r_edge_cnt + CNT_W'(1);
          end
        end
        if (r_timer == '0) begin
          w_gate_nxt   = 1'b0;
          w_count_nxt  = w_edge_cnt_nxt;
          w_done_set   = 1'b1;
          w_shadow_nxt = r_gate_len;
          w_state_nxt  = w_cont_nxt ? S_GAP : S_IDLE;
        end else begin
          w_timer_nxt = r_timer - GATE_W'(1);
        end
      end
      S_GAP: begin
        // A zero length written during the previous gate ends continuous mode
        if (w_cont_nxt && (r_shadow != '0)) begin
          w_state_nxt    = S_GATE;
          w_gate_nxt     = 1'b1;
          w_timer_nxt    = r_shadow - GATE_W'(1);
          w_edge_cnt_nxt = '0;
          w_ovf_clr      = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_gate_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_gate     <= 1'b0;
      r_timer    <= '0;
      r_shadow   <= '0;
      r_edge_cnt <= '0;
      r_count    <= '0;
      r_gate_len <= '0;
      r_cont     <= 1'b0;
      r_done     <= 1'b0;
      r_ovf      <= 1'b0;
      r_rdata    <= '0;
    end else begin
      r_gate     <= w_gate_nxt;
      r_timer    <= w_timer_nxt;
      r_shadow   <= w_shadow_nxt;
      r_edge_cnt <= w_edge_cnt_nxt;
      r_count    <= w_count_nxt;
      r_cont     <= w_cont_nxt;
      r_rdata    <= w_rdata;
      if (w_wr_gate_len) begin
        r_gate_len <= writedata[GATE_W-1:0];
      end
      // Set beats the software clear when both land on the same edge
      if (w_done_set) begin
        r_done <= 1'b1;
      end else if (w_wr_status) begin
        r_done <= 1'b0;
      end
      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end else if (w_ovf_clr || w_wr_status) begin
        r_ovf <= 1'b0;
      end
    end
  end

`ifdef FREQ_GATE_IRQ_EN
  logic r_ie;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ie <= 1'b0;
    end else if (w_wr_ctrl) begin
      r_ie <= writedata[2];
    end
  end

  assign w_ie = r_ie;
  assign irq  = r_done & r_ie;
`else
  assign w_ie = 1'b0;
`endif

  always_comb begin
    w_rdata = '0;
    case (address)
      c_ADDR_CTRL:     w_rdata = {29'd0, w_ie, r_cont, w_busy};
      c_ADDR_GATE_LEN: w_rdata = 32'(r_gate_len);
      c_ADDR_COUNT:    w_rdata = 32'(r_count);
      c_ADDR_STATUS:   w_rdata = {30'd0, r_ovf, r_done};
      default:         w_rdata = '0;
    endcase
  end

  assign readdata = r_rdata;
  assign gate_out = r_gate;

endmodule
`default_nettype wire
